// File: rtl/wide_uart_adapter_if.sv
// Stream bundle between the wide-word side and the UART byte side of wide_uart_adapter.
// The master modport is the adapter's view; slave is the surrounding system's view.
interface wide_uart_adapter_if #(
  parameter int DATA_WIDTH = 64
);
  logic [DATA_WIDTH-1:0] s_axis_tdata;
  logic                  s_axis_tvalid;
  logic                  s_axis_tready;
  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic [7:0]            tx_byte_tdata;
  logic                  tx_byte_tvalid;
  logic                  tx_byte_tready;
  logic [7:0]            rx_byte_tdata;
  logic                  rx_byte_tvalid;
  logic                  rx_byte_tready;

  modport master (
    input  s_axis_tdata, s_axis_tvalid,
    output s_axis_tready,
    output m_axis_tdata, m_axis_tvalid,
    input  m_axis_tready,
    output tx_byte_tdata, tx_byte_tvalid,
    input  tx_byte_tready,
    input  rx_byte_tdata, rx_byte_tvalid,
    output rx_byte_tready
  );

  modport slave (
    output s_axis_tdata, s_axis_tvalid,
    input  s_axis_tready,
    input  m_axis_tdata, m_axis_tvalid,
    output m_axis_tready,
    input  tx_byte_tdata, tx_byte_tvalid,
    output tx_byte_tready,
    output rx_byte_tdata, rx_byte_tvalid,
    input  rx_byte_tready
  );
endinterface

// File: rtl/wide_uart_adapter.sv
// Serialises DATA_WIDTH-bit stream words into UART bytes and reassembles received bytes
// into words, with selectable byte order and an optional RX inter-byte timeout.
module wide_uart_adapter #(
  parameter int DATA_WIDTH = 64,
  parameter int MSB_FIRST  = 1,
  parameter int RX_TIMEOUT = 0,
  parameter int TO_WIDTH   = 24
) (
  input  logic                clk,
  input  logic                rst,
  wide_uart_adapter_if.master bus,
  output logic                rx_partial,
  output logic                rx_timeout,
  output logic                tx_active
);

  localparam int N     = DATA_WIDTH / 8;
  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N - 1);
  localparam logic [TO_WIDTH-1:0] TO_LAST  = (RX_TIMEOUT > 0) ? TO_WIDTH'(RX_TIMEOUT - 1) : '0;

  typedef enum logic {TX_IDLE, TX_SEND}    tx_state_t;
  typedef enum logic {RX_COLLECT, RX_HOLD} rx_state_t;

  // Wire position of byte number idx within the word for the configured byte order.
  function automatic int byte_pos(input logic [IDX_W-1:0] idx);
    return (MSB_FIRST != 0) ? (N - 1 - int'(idx)) : int'(idx);
  endfunction

  tx_state_t             tx_state;
  logic [DATA_WIDTH-1:0] tx_buf;
  logic [IDX_W-1:0]      tx_idx;
  logic [IDX_W-1:0]      tx_idx_nxt;

  rx_state_t             rx_state;
  logic [DATA_WIDTH-1:0] rx_buf;
  logic [IDX_W-1:0]      rx_idx;
  logic [TO_WIDTH-1:0]   rx_cnt;

  assign tx_idx_nxt      = tx_idx + 1'b1;
  assign bus.m_axis_tdata = rx_buf;

  // NOTE: every state register below is updated with <= so all reads in a block see the
  // pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_state           <= TX_IDLE;
      tx_buf             <= '0;
      tx_idx             <= '0;
      bus.s_axis_tready  <= 1'b1;
      bus.tx_byte_tvalid <= 1'b0;
      bus.tx_byte_tdata  <= '0;
      tx_active          <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (bus.s_axis_tvalid) begin
            tx_buf             <= bus.s_axis_tdata;
            tx_idx             <= '0;
            bus.tx_byte_tdata  <= bus.s_axis_tdata[8*byte_pos('0) +: 8];
            bus.tx_byte_tvalid <= 1'b1;
            bus.s_axis_tready  <= 1'b0;
            tx_active          <= 1'b1;
            tx_state           <= TX_SEND;
          end
        end
        TX_SEND: begin
          // Byte and valid only move on a completed transfer, so they hold under back-pressure.
          if (bus.tx_byte_tready) begin
            if (tx_idx == IDX_LAST) begin
              bus.tx_byte_tvalid <= 1'b0;
              bus.tx_byte_tdata  <= '0;
              bus.s_axis_tready  <= 1'b1;
              tx_active          <= 1'b0;
              tx_state           <= TX_IDLE;
            end else begin
              tx_idx            <= tx_idx_nxt;
              bus.tx_byte_tdata <= tx_buf[8*byte_pos(tx_idx_nxt) +: 8];
            end
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_state           <= RX_COLLECT;
      rx_buf             <= '0;
      rx_idx             <= '0;
      rx_cnt             <= '0;
      bus.rx_byte_tready <= 1'b1;
      bus.m_axis_tvalid  <= 1'b0;
      rx_partial         <= 1'b0;
      rx_timeout         <= 1'b0;
    end else begin
      rx_timeout <= 1'b0;
      case (rx_state)
        RX_COLLECT: begin
          if (bus.rx_byte_tvalid) begin
            // An arriving byte takes priority over a timeout expiring on the same edge.
            rx_buf[8*byte_pos(rx_idx) +: 8] <= bus.rx_byte_tdata;
            rx_cnt <= '0;
            if (rx_idx == IDX_LAST) begin
              bus.m_axis_tvalid  <= 1'b1;
              bus.rx_byte_tready <= 1'b0;
              rx_partial         <= 1'b0;
              rx_state           <= RX_HOLD;
            end else begin
              rx_idx     <= rx_idx + 1'b1;
              rx_partial <= 1'b1;
            end
          end else if (RX_TIMEOUT > 0 && rx_idx != '0) begin
            if (rx_cnt == TO_LAST) begin
              rx_buf     <= '0;
              rx_idx     <= '0;
              rx_cnt     <= '0;
              rx_partial <= 1'b0;
              rx_timeout <= 1'b1;
            end else begin
              rx_cnt <= rx_cnt + 1'b1;
            end
          end
        end
        RX_HOLD: begin
          if (bus.m_axis_tready) begin
            bus.m_axis_tvalid  <= 1'b0;
            bus.rx_byte_tready <= 1'b1;
            rx_buf             <= '0;
            rx_idx             <= '0;
            rx_cnt             <= '0;
            rx_state           <= RX_COLLECT;
          end
        end
        default: rx_state <= RX_COLLECT;
      endcase
    end
  end

endmodule
